// File: rtl/bnw_pkg.sv
// Shared constants and event type for the piano-key front end.
package bnw_pkg;

    localparam int NUM_KEYS = 8;
    localparam int IDX_W    = $clog2(NUM_KEYS);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             press;
    } key_evt_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first: scans req starting at 'start', wrapping to 0.
module rr_picker #(
    parameter int NUM_KEYS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_KEYS-1:0] req,
    input  logic [IDX_W-1:0]    start,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int off = 0; off < NUM_KEYS; off++) begin
            j = int'(start) + off;
            if (j >= NUM_KEYS) j = j - NUM_KEYS;
            jj = j[IDX_W-1:0];
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Converts debounced key levels into a round-robin serialised press/release event
// stream with a 1-entry output slot, and tracks the most recently pressed key.
module key_event_arbiter #(
    parameter int NUM_KEYS = bnw_pkg::NUM_KEYS,
    parameter int IDX_W    = bnw_pkg::IDX_W,
    parameter int DROP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_db,
    input  logic                evt_ready,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                active_valid,
    output logic [IDX_W-1:0]    active_key,
    output logic [DROP_W-1:0]   drop_cnt
);

    import bnw_pkg::*;

    // Several keys can overflow in the same cycle, so add one per set mask bit.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [NUM_KEYS-1:0] inc_mask);
        logic [DROP_W-1:0] acc;
        acc = a;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (inc_mask[i] && (acc != {DROP_W{1'b1}})) acc = acc + DROP_W'(1);
        end
        return acc;
    endfunction

    logic [NUM_KEYS-1:0] key_q, pend_press, pend_rel;
    logic [NUM_KEYS-1:0] rise, fall, eligible;
    logic [NUM_KEYS-1:0] sel, clr_press, clr_rel, drop_mask;
    logic [IDX_W-1:0]    rr_ptr, pick_idx;
    logic                pick_found, load, issue_press;
    key_evt_t            slot_q;

    // Edge detect and pending-set bookkeeping
    assign rise     = key_db & ~key_q;
    assign fall     = ~key_db & key_q;
    assign eligible = pend_press | pend_rel;

    rr_picker #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req   (eligible),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign load        = pick_found && (!evt_valid || evt_ready);
    assign issue_press = pend_press[pick_idx];
    assign sel         = load ? (NUM_KEYS'(1) << pick_idx) : '0;
    assign clr_press   = sel & {NUM_KEYS{issue_press}};
    assign clr_rel     = sel & {NUM_KEYS{~issue_press}};
    assign drop_mask   = (rise & pend_press & ~clr_press) | (fall & pend_rel & ~clr_rel);

    assign evt_key   = slot_q.idx;
    assign evt_press = slot_q.press;

    // Registered state: pending bits, output slot, active note
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q        <= '0;
            pend_press   <= '0;
            pend_rel     <= '0;
            rr_ptr       <= '0;
            drop_cnt     <= '0;
            evt_valid    <= 1'b0;
            slot_q       <= '0;
            active_valid <= 1'b0;
            active_key   <= '0;
        end else begin
            key_q      <= key_db;
            pend_press <= (pend_press & ~clr_press) | rise;
            pend_rel   <= (pend_rel & ~clr_rel) | fall;
            drop_cnt   <= sat_add(drop_cnt, drop_mask);

            if (load) begin
                evt_valid    <= 1'b1;
                slot_q.idx   <= pick_idx;
                slot_q.press <= issue_press;
                rr_ptr       <= (pick_idx == IDX_W'(NUM_KEYS - 1)) ? '0 : pick_idx + IDX_W'(1);
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (evt_valid && evt_ready) begin
                if (slot_q.press) begin
                    active_valid <= 1'b1;
                    active_key   <= slot_q.idx;
                end else if (active_valid && (slot_q.idx == active_key)) begin
                    active_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-free
// behavioural model of the event arbiter.
module tb_key_event_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_db;
    logic       evt_ready;
    logic       evt_valid;
    logic [2:0] evt_key;
    logic       evt_press;
    logic       active_valid;
    logic [2:0] active_key;
    logic [7:0] drop_cnt;

    key_event_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .key_db       (key_db),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_key      (evt_key),
        .evt_press    (evt_press),
        .active_valid (active_valid),
        .active_key   (active_key),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // model state
    bit m_kq[N];
    bit m_pp[N];
    bit m_pr[N];
    int m_rr, m_key, m_act_k, m_drop;
    bit m_valid, m_press, m_act_v;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model_step();
        int  g, k;
        bit  found, load, pr;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_kq[i] = 0; m_pp[i] = 0; m_pr[i] = 0;
            end
            m_rr = 0; m_key = 0; m_act_k = 0; m_drop = 0;
            m_valid = 0; m_press = 0; m_act_v = 0;
        end else begin
            found = 0; g = 0;
            for (int off = 0; off < N; off++) begin
                k = (m_rr + off) % N;
                if (!found && (m_pp[k] || m_pr[k])) begin
                    found = 1; g = k;
                end
            end
            if (m_valid && evt_ready) begin
                if (m_press) begin
                    m_act_v = 1; m_act_k = m_key;
                end else if (m_act_v && m_key == m_act_k) begin
                    m_act_v = 0;
                end
            end
            load = found && (!m_valid || evt_ready);
            if (load) begin
                pr = m_pp[g];
                if (pr) m_pp[g] = 0;
                else    m_pr[g] = 0;
                m_valid = 1; m_key = g; m_press = pr; m_rr = (g + 1) % N;
            end else if (evt_ready) begin
                m_valid = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (key_db[i] && !m_kq[i]) begin
                    if (m_pp[i] && m_drop < 255) m_drop++;
                    m_pp[i] = 1;
                end
                if (!key_db[i] && m_kq[i]) begin
                    if (m_pr[i] && m_drop < 255) m_drop++;
                    m_pr[i] = 1;
                end
                m_kq[i] = key_db[i];
            end
        end
    endtask

    // One clock: advance model with current inputs, clock DUT, compare at negedge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("evt_valid", int'(evt_valid), int'(m_valid));
        if (m_valid) begin
            chk("evt_key", int'(evt_key), m_key);
            chk("evt_press", int'(evt_press), int'(m_press));
        end
        chk("active_valid", int'(active_valid), int'(m_act_v));
        chk("active_key", int'(active_key), m_act_k);
        chk("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_db = '0; evt_ready = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_outputs", int'({evt_valid, evt_key, evt_press, active_valid, active_key, drop_cnt}), 0);

        // press key 3: valid two edges after the change
        key_db = 8'h08;
        step();
        chk("k3_lat1_valid", int'(evt_valid), 0);
        step();
        chk("k3_valid", int'(evt_valid), 1);
        chk("k3_key", int'(evt_key), 3);
        chk("k3_press", int'(evt_press), 1);
        step();
        chk("k3_active_v", int'(active_valid), 1);
        chk("k3_active_k", int'(active_key), 3);
        key_db = 8'h00;
        repeat (3) step();
        chk("k3_released", int'(active_valid), 0);

        // all keys at once, then all released
        do_reset();
        key_db = 8'hFF;
        step();
        for (int i = 0; i < N; i++) begin
            step();
            chk("all_press_key", int'(evt_key), i);
            chk("all_press_dir", int'(evt_press), 1);
        end
        key_db = 8'h00;
        step();
        chk("all_gap_valid", int'(evt_valid), 0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("all_rel_valid", int'(evt_valid), 1);
            chk("all_rel_key", int'(evt_key), i);
            chk("all_rel_dir", int'(evt_press), 0);
        end
        step();

        // backpressure holds the slot stable
        evt_ready = 1'b0; key_db = 8'h20;
        repeat (2) step();
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hold_valid", int'(evt_valid), 1);
            chk("hold_key", int'(evt_key), 5);
            chk("hold_press", int'(evt_press), 1);
        end
        evt_ready = 1'b1;
        step();
        chk("hold_accepted", int'(evt_valid), 0);
        chk("hold_active", int'(active_key), 5);
        step();
        chk("hold_no_dup", int'(evt_valid), 0);
        key_db = 8'h00;
        repeat (3) step();

        // overflow on key 2 while slot is occupied by key 0
        do_reset();
        evt_ready = 1'b0;
        key_db = 8'h01; repeat (2) step();
        key_db = 8'h05; step();
        key_db = 8'h01; step();
        key_db = 8'h05; step();
        chk("drop_one", int'(drop_cnt), 1);
        chk("drop_slot_key", int'(evt_key), 0);
        evt_ready = 1'b1;
        step();
        chk("drop_ev1_key", int'(evt_key), 2);
        chk("drop_ev1_press", int'(evt_press), 1);
        step();
        chk("drop_ev2_key", int'(evt_key), 2);
        chk("drop_ev2_press", int'(evt_press), 0);
        step();
        chk("drop_no_more", int'(evt_valid), 0);
        key_db = 8'h00;
        repeat (4) step();

        // active note only cleared by release of the sounding key
        do_reset();
        key_db = 8'h02; repeat (3) step();
        key_db = 8'h12; repeat (3) step();
        chk("act_4", int'(active_key), 4);
        key_db = 8'h10; repeat (3) step();
        chk("act_still_4", int'(active_key), 4);
        chk("act_still_v", int'(active_valid), 1);
        key_db = 8'h00; repeat (3) step();
        chk("act_cleared", int'(active_valid), 0);

        // reset while an event is held
        evt_ready = 1'b0; key_db = 8'h40;
        repeat (3) step();
        chk("rstmid_held", int'(evt_key), 6);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstmid_zero", int'({evt_valid, evt_key, evt_press, active_valid, active_key, drop_cnt}), 0);
        evt_ready = 1'b1;
        repeat (2) step();
        chk("rstmid_repress_v", int'(evt_valid), 1);
        chk("rstmid_repress_k", int'(evt_key), 6);
        chk("rstmid_repress_p", int'(evt_press), 1);

        // drop counter saturation
        evt_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            key_db = (c % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end
        chk("drop_sat", int'(drop_cnt), 255);
        do_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) key_db[$urandom_range(0, 7)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
